// File: rtl/demux_3_router_pkg.sv
// Shared definitions for the 1-to-3 registered demultiplexer and its slots.
// Select encoding matches the 3:1 mux so that mux(demux(x)) == x.
package demux_3_router_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_CH    = 3;

  typedef enum logic [1:0] {
    SEL_CH0  = 2'b00,
    SEL_CH1  = 2'b01,
    SEL_CH2A = 2'b10,
    SEL_CH2B = 2'b11
  } sel_e;

  // Both codes with s1=1 land on channel 2, as D2 does in the 3:1 mux.
  function automatic logic [NUM_CH-1:0] decode_sel(input logic [1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot = 3'b100;
    case (sel)
      SEL_CH0:  onehot = 3'b001;
      SEL_CH1:  onehot = 3'b010;
      SEL_CH2A: onehot = 3'b100;
      SEL_CH2B: onehot = 3'b100;
      default:  onehot = 3'b100;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_3_slot.sv
// One output channel: a 1-entry holding register with valid flag and a
// saturating count of accepted words.
module demux_3_slot import demux_3_router_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  // A load wins over a drain, so simultaneous drain+load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/demux_3_router.sv
// 1-to-3 registered demultiplexer: steers one valid/ready stream to one of
// three independently backpressured channels selected by {s1,s0}.
module demux_3_router import demux_3_router_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  s0,
  input  logic                  s1,
  output logic [3*WIDTH-1:0]    out_data,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  input  logic                  cnt_clr,
  output logic [3*CNT_W-1:0]    cnt
);

  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;
  logic              accept;

  // Only the targeted channel's room matters, so a stalled channel blocks
  // nothing but inputs aimed at it.
  assign target   = decode_sel({s1, s0});
  assign in_ready = |(target & (~out_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign load     = accept ? target : '0;
  assign drain    = out_valid & out_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_3_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .drain     (drain[k]),
      .clr       (cnt_clr),
      .load_data (in_data),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .valid     (out_valid[k]),
      .cnt       (cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
